// File: rtl/decoder_scan_driver.sv
// Select-code sequencer for a 2-to-4 decoder: prescaled up/down scan of W
// with continuous or single-sweep operation and step/wrap/busy status.
module decoder_scan_driver #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic                 START,
  input  logic                 STOP,
  input  logic                 MODE,
  input  logic                 DIR,
  input  logic [DIV_WIDTH-1:0] DIV,
  output logic [1:0]           W,
  output logic                 BUSY,
  output logic                 TICK,
  output logic                 WRAP
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           w_q, w_d;
  logic                 busy_q, busy_d;
  logic                 tick_q, tick_d;
  logic                 wrap_q, wrap_d;
  logic                 dir_q, dir_d;
  logic                 mode_q, mode_d;
  logic [DIV_WIDTH-1:0] pre_q, pre_d;
  logic                 term;

  // Terminal code depends on the direction latched at START.
  assign term = dir_q ? (w_q == 2'd0) : (w_q == 2'd3);

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    busy_d  = busy_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    dir_d   = dir_q;
    mode_d  = mode_q;
    pre_d   = pre_q;
    if (STOP) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      pre_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (START) begin
            state_d = RUN;
            dir_d   = DIR;
            mode_d  = MODE;
            w_d     = DIR ? 2'd3 : 2'd0;
            pre_d   = '0;
            busy_d  = 1'b1;
          end
        end
        RUN: begin
          if (EN) begin
            if (pre_q == DIV) begin
              pre_d  = '0;
              tick_d = 1'b1;
              w_d    = dir_q ? w_q - 2'd1 : w_q + 2'd1;
              if (term) begin
                wrap_d = 1'b1;
                if (mode_q) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                end
              end
            end else begin
              // Free-running wrap covers a DIV lowered below the count.
              pre_d = pre_q + DIV_WIDTH'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      w_q     <= 2'd0;
      busy_q  <= 1'b0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      dir_q   <= 1'b0;
      mode_q  <= 1'b0;
      pre_q   <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      busy_q  <= busy_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      pre_q   <= pre_d;
    end
  end

  assign W    = w_q;
  assign BUSY = busy_q;
  assign TICK = tick_q;
  assign WRAP = wrap_q;

endmodule

// File: tb/tb_decoder_scan_driver.sv
// Directed bench for decoder_scan_driver: scan, sweep, pause, stop and
// reset scenarios with hand-computed expectations.
module tb_decoder_scan_driver;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       EN = 1'b0;
  logic       START = 1'b0;
  logic       STOP = 1'b0;
  logic       MODE = 1'b0;
  logic       DIR = 1'b0;
  logic [7:0] DIV = 8'd0;
  logic [1:0] W;
  logic       BUSY, TICK, WRAP;

  int total = 0;
  int passed = 0;
  int failed = 0;

  decoder_scan_driver #(.DIV_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .START(START), .STOP(STOP),
    .MODE(MODE), .DIR(DIR), .DIV(DIV),
    .W(W), .BUSY(BUSY), .TICK(TICK), .WRAP(WRAP)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [1:0] w,
                         input logic b, input logic t,
                         input logic r);
    chk({tag, ".W"}, {6'd0, W}, {6'd0, w});
    chk({tag, ".BUSY"}, {7'd0, BUSY}, {7'd0, b});
    chk({tag, ".TICK"}, {7'd0, TICK}, {7'd0, t});
    chk({tag, ".WRAP"}, {7'd0, WRAP}, {7'd0, r});
  endtask

  logic [1:0] exp_w [6];

  initial begin
    // 1: reset and idle hold
    step();
    chk_out("rst", 2'd0, 1'b0, 1'b0, 1'b0);
    RST = 1'b0;
    EN = 1'b1;
    repeat (3) step();
    chk_out("idle", 2'd0, 1'b0, 1'b0, 1'b0);

    // 2: continuous up scan, DIV=2
    exp_w = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    DIV = 8'd2; MODE = 1'b0; DIR = 1'b0; START = 1'b1;
    step();
    START = 1'b0;
    chk_out("c_start", 2'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("c_gap1.TICK", {7'd0, TICK}, 8'd0);
      step();
      chk("c_gap2.TICK", {7'd0, TICK}, 8'd0);
      step();
      chk_out("c_tick", exp_w[i], 1'b1, 1'b1, i == 3);
    end
    STOP = 1'b1;
    step();
    STOP = 1'b0;
    chk_out("c_stop", 2'd2, 1'b0, 1'b0, 1'b0);

    // 3: single sweep down, DIV=0
    exp_w = '{2'd2, 2'd1, 2'd0, 2'd3, 2'd0, 2'd0};
    DIV = 8'd0; MODE = 1'b1; DIR = 1'b1; START = 1'b1;
    step();
    START = 1'b0; MODE = 1'b0; DIR = 1'b0;
    chk_out("s_start", 2'd3, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_out("s_tick", exp_w[i], i != 3, 1'b1, i == 3);
    end
    step();
    chk_out("s_done", 2'd3, 1'b0, 1'b0, 1'b0);

    // 4: pause mid-period, DIV=4
    DIV = 8'd4; START = 1'b1;
    step();
    START = 1'b0;
    chk_out("p_start", 2'd0, 1'b1, 1'b0, 1'b0);
    repeat (2) step();
    EN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out("p_hold", 2'd0, 1'b1, 1'b0, 1'b0);
    end
    EN = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk_out("p_resume", 2'd0, 1'b1, 1'b0, 1'b0);
    end
    step();
    chk_out("p_tick", 2'd1, 1'b1, 1'b1, 1'b0);
    STOP = 1'b1;
    step();
    STOP = 1'b0;
    chk_out("p_stop", 2'd1, 1'b0, 1'b0, 1'b0);

    // 5: STOP beats START; STOP beats a tick
    START = 1'b1; STOP = 1'b1;
    step();
    START = 1'b0; STOP = 1'b0;
    chk_out("ss_idle", 2'd1, 1'b0, 1'b0, 1'b0);
    step();
    chk_out("ss_idle2", 2'd1, 1'b0, 1'b0, 1'b0);
    DIV = 8'd1; START = 1'b1;
    step();
    START = 1'b0;
    chk_out("st_start", 2'd0, 1'b1, 1'b0, 1'b0);
    step();
    STOP = 1'b1;
    step();
    STOP = 1'b0;
    chk_out("st_stop", 2'd0, 1'b0, 1'b0, 1'b0);
    step();
    chk_out("st_after", 2'd0, 1'b0, 1'b0, 1'b0);

    // 6: async reset mid-run, then clean restart
    DIV = 8'd0; START = 1'b1;
    step();
    START = 1'b0;
    step();
    step();
    chk_out("r_run", 2'd2, 1'b1, 1'b1, 1'b0);
    #2 RST = 1'b1;
    #1;
    chk_out("r_async", 2'd0, 1'b0, 1'b0, 1'b0);
    #1 RST = 1'b0;
    START = 1'b1;
    step();
    START = 1'b0;
    chk_out("r_restart", 2'd0, 1'b1, 1'b0, 1'b0);
    step();
    chk_out("r_tick", 2'd1, 1'b1, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
